// File: rtl/mult_div_unit_if.sv
// EX-stage request bus and HI/LO result view of the multiply/divide unit.
interface mult_div_unit_if;
  logic        start;
  logic        imm_write;
  logic [2:0]  op;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  // EX stage / hazard unit side
  modport master (
    output start, imm_write, op, cancel, a, b,
    input  busy, hi, lo
  );

  // Multiply/divide unit side
  modport slave (
    input  start, imm_write, op, cancel, a, b,
    output busy, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Fixed-latency multiply/divide unit owning the architectural HI/LO registers.
// The result is computed when the request is accepted and held until the
// latency counter expires, so HI/LO change only on the final busy edge.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  mult_div_unit_if.slave    bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               res_wr;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic               busy_q;

  logic               is_mult_c;
  logic               is_div_c;
  logic [63:0]        prod_s_c;
  logic [63:0]        prod_u_c;
  logic               a_neg_c;
  logic               b_neg_c;
  logic [31:0]        mag_a_c;
  logic [31:0]        mag_b_c;
  logic [31:0]        q_mag_c;
  logic [31:0]        r_mag_c;
  logic [31:0]        quot_c;
  logic [31:0]        rem_c;
  logic               div_zero_c;

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Result datapath: products, and sign-magnitude division so the
  // 0x80000000 / -1 case falls out without overflow.
  always_comb begin
    is_mult_c  = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    is_div_c   = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    prod_s_c   = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    prod_u_c   = {32'd0, bus.a} * {32'd0, bus.b};
    a_neg_c    = (bus.op == OP_DIV) && bus.a[31];
    b_neg_c    = (bus.op == OP_DIV) && bus.b[31];
    mag_a_c    = a_neg_c ? 32'(-bus.a) : bus.a;
    mag_b_c    = b_neg_c ? 32'(-bus.b) : bus.b;
    div_zero_c = (bus.b == 32'd0);
    q_mag_c    = mag_a_c / (div_zero_c ? 32'd1 : mag_b_c);
    r_mag_c    = mag_a_c % (div_zero_c ? 32'd1 : mag_b_c);
    quot_c     = (a_neg_c ^ b_neg_c) ? 32'(-q_mag_c) : q_mag_c;
    rem_c      = a_neg_c ? 32'(-r_mag_c) : r_mag_c;
  end

  // Control FSM, latency counter, pending result and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            // start has priority; imm_write in the same cycle is dropped
            if (is_mult_c) begin
              res_hi <= (bus.op == OP_MULT) ? prod_s_c[63:32] : prod_u_c[63:32];
              res_lo <= (bus.op == OP_MULT) ? prod_s_c[31:0]  : prod_u_c[31:0];
              res_wr <= 1'b1;
              cnt    <= CNT_W'(MULT_CYCLES);
              state  <= RUN;
              busy_q <= 1'b1;
            end else if (is_div_c) begin
              res_hi <= rem_c;
              res_lo <= quot_c;
              res_wr <= !div_zero_c;
              cnt    <= CNT_W'(DIV_CYCLES);
              state  <= RUN;
              busy_q <= 1'b1;
            end
          end else if (bus.imm_write && !bus.cancel) begin
            if (bus.op == OP_MTHI) begin
              hi_q <= bus.a;
            end else if (bus.op == OP_MTLO) begin
              lo_q <= bus.a;
            end
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            if (res_wr) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against an arithmetic model.
module tb_mult_div_unit;

  localparam int unsigned MULT_CYCLES = 5;
  localparam int unsigned DIV_CYCLES  = 10;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit_if bus();

  mult_div_unit #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: architectural effect of an accepted mult/div on the model HI/LO.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    case (op)
      3'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = longint'(sa * sb);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd1: begin
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = ua * ub;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd2: if (b != 0) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      3'd3: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      default: ;
    endcase
  endtask

  // Issue a mult/div at the current negedge; return at the negedge of the first idle cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit cancel_mid, input bit with_imm);
    int n;
    int exp_n;
    exp_n = (op < 3'd2) ? MULT_CYCLES : DIV_CYCLES;
    bus.start     = 1'b1;
    bus.imm_write = with_imm;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.imm_write = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    model_op(op, a, b);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      n++;
      bus.cancel = cancel_mid && (n == 2);
      bus.a      = $urandom;
    end
    bus.cancel = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    chk({tag, "_hi"}, bus.hi, m_hi);
    chk({tag, "_lo"}, bus.lo, m_lo);
  endtask

  // Immediate HI/LO write at the current negedge.
  task automatic imm(input string tag, input logic [2:0] op, input logic [31:0] a);
    bus.imm_write = 1'b1;
    bus.op        = op;
    bus.a         = a;
    @(posedge clk);
    #1;
    bus.imm_write = 1'b0;
    if (op == 3'd4) m_hi = a;
    if (op == 3'd5) m_lo = a;
    @(negedge clk);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_hi"}, bus.hi, m_hi);
    chk({tag, "_lo"}, bus.lo, m_lo);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    checks = 0;
    errors = 0;
    m_hi = '0;
    m_lo = '0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.imm_write = 1'b0;
    bus.op = 3'd0;
    bus.cancel = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases, including back-to-back issue
    run_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    chk("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", bus.lo, 32'hFFFF_FFEB);
    run_op("multu", 3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    chk("multu_hi_const", bus.hi, 32'h0000_0006);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_lo_const", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi_const", bus.hi, 32'hFFFF_FFFF);
    run_op("divu", 3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    chk("divu_lo_const", bus.lo, 32'd14);
    chk("divu_hi_const", bus.hi, 32'd2);

    // Immediate writes and divide by zero
    imm("mthi", 3'd4, 32'h1234_5678);
    imm("mtlo", 3'd5, 32'hCAFE_F00D);
    run_op("divu_zero", 3'd3, 32'd55, 32'd0, 1'b0, 1'b0);
    chk("divu_zero_hi_kept", bus.hi, 32'h1234_5678);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("div_ovf_lo_const", bus.lo, 32'h8000_0000);
    chk("div_ovf_hi_const", bus.hi, 32'd0);

    // Ignored requests: imm_write with arithmetic op, start with mthi
    imm("imm_noop", 3'd0, 32'hDEAD_BEEF);
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h1111_1111;
    @(posedge clk); #1; bus.start = 1'b0;
    @(negedge clk);
    chk("start_mthi_busy", 32'(bus.busy), 32'd0);
    chk("start_mthi_hi", bus.hi, m_hi);

    // Cancel behaviour
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 3'd0; bus.a = 32'd9; bus.b = 32'd9;
    @(posedge clk); #1; bus.start = 1'b0; bus.cancel = 1'b0;
    @(negedge clk);
    chk("cancel_start_busy", 32'(bus.busy), 32'd0);
    chk("cancel_start_hi", bus.hi, m_hi);
    chk("cancel_start_lo", bus.lo, m_lo);
    run_op("cancel_mid", 3'd1, 32'h0001_0000, 32'h0003_0000, 1'b1, 1'b0);
    run_op("start_imm", 3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1);

    // Randomized mix of operations and immediate writes
    for (int k = 0; k < 24; k++) begin
      rop = 3'($urandom_range(0, 5));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      if (rop >= 3'd4) imm("rnd_imm", rop, ra);
      else             run_op("rnd_op", rop, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset during the third busy cycle of a div
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd1000; bus.b = 32'd3;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    chk("mid_reset_busy", 32'(bus.busy), 32'd0);
    chk("mid_reset_hi", bus.hi, 32'd0);
    chk("mid_reset_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_reset_mult", 3'd0, 32'd123, 32'hFFFF_FF00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
